// File: rtl/seg_scan_if.sv
// Control bus between the game FSM and the seven-segment scan controller.
// Handshake: load_d is a single-cycle request, sampled on the rising clock
// edge and accepted only when busy_d is low. busy_d rises on the cycle after
// acceptance and falls when the displayed value is updated. A request made
// while busy_d is high is dropped; load_d may be raised again on the cycle
// busy_d falls.
interface seg_scan_if #(
  parameter int VAL_W = 14
);
  logic [2:0]       mode_d;
  logic [VAL_W-1:0] value_d;
  logic             load_d;
  logic             blink_en_d;
  logic             busy_d;
  logic [1:0]       dbg_state_d;  // conversion FSM state, for observation only

  modport master (
    output mode_d, value_d, load_d, blink_en_d,
    input  busy_d, dbg_state_d
  );

  modport slave (
    input  mode_d, value_d, load_d, blink_en_d,
    output busy_d, dbg_state_d
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment display controller: scans NUM_DIGITS common-anode
// digits and shows either a fixed game message or a binary count converted to
// BCD by a sequential double-dabble engine.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int VAL_W       = 14,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_LOG2  = 9
) (
  input  logic                  clk_d,
  input  logic                  rst_n_d,
  seg_scan_if.slave             ctrl,
  output logic [NUM_DIGITS-1:0] an_d,
  output logic [7:0]            seg_d
);

  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int ITER_W = $clog2(VAL_W + 1);
  localparam int BCD_W  = 4 * NUM_DIGITS;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] OVF_LIMIT = pow10(NUM_DIGITS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } conv_state_e;

  // Add 3 to every BCD nibble that is 5 or more before the shift.
  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [7:0] digit_code(input logic [3:0] n);
    case (n)
      4'd0:    digit_code = 8'hC0;
      4'd1:    digit_code = 8'hF9;
      4'd2:    digit_code = 8'hA4;
      4'd3:    digit_code = 8'hB0;
      4'd4:    digit_code = 8'h99;
      4'd5:    digit_code = 8'h92;
      4'd6:    digit_code = 8'h82;
      4'd7:    digit_code = 8'hF8;
      4'd8:    digit_code = 8'h80;
      4'd9:    digit_code = 8'h90;
      default: digit_code = 8'hFF;
    endcase
  endfunction

  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [BLINK_LOG2:0]   blink_q;

  conv_state_e           state_q, state_d;
  logic [VAL_W-1:0]      bin_q, bin_d;
  logic [VAL_W-1:0]      val_q, val_d;
  logic [BCD_W-1:0]      scr_q, scr_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic [BCD_W-1:0]      disp_q, disp_d;
  logic                  ovf_q, ovf_d;

  logic [NUM_DIGITS-1:0] an_q, an_n;
  logic [7:0]            seg_q, seg_n;

  // Refresh counter, digit index and blink phase counter.
  always_ff @(posedge clk_d) begin
    if (!rst_n_d) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      blink_q <= '0;
    end else if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_q   <= '0;
      idx_q   <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      blink_q <= blink_q + (BLINK_LOG2 + 1)'(1);
    end else begin
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Conversion FSM and displayed-value registers.
  always_ff @(posedge clk_d) begin
    if (!rst_n_d) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      val_q   <= '0;
      scr_q   <= '0;
      iter_q  <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      val_q   <= val_d;
      scr_q   <= scr_d;
      iter_q  <= iter_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
    end
  end

  // Double-dabble next state: one adjust+shift per SHIFT cycle; the displayed
  // value only changes in DONE so partial results are never shown.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    val_d   = val_q;
    scr_d   = scr_q;
    iter_d  = iter_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (ctrl.load_d) begin
          val_d   = ctrl.value_d;
          bin_d   = ctrl.value_d;
          scr_d   = '0;
          iter_d  = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {scr_d, bin_d} = {dabble_adj(scr_q), bin_q} << 1;
        iter_d = iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(VAL_W - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        disp_d  = scr_q;
        ovf_d   = (64'(val_q) >= OVF_LIMIT);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ctrl.busy_d      = (state_q != S_IDLE);
  assign ctrl.dbg_state_d = state_q;

  // Segment pattern for the digit currently selected by the scan index.
  always_comb begin
    logic       lead_nz;
    logic [3:0] nib;
    seg_n   = 8'hFF;
    an_n    = ~(NUM_DIGITS'(1) << idx_q);
    lead_nz = 1'b0;
    nib     = disp_q[4*idx_q +: 4];
    for (int j = 0; j < NUM_DIGITS; j++)
      if (j >= int'(idx_q) && disp_q[4*j +: 4] != 4'd0) lead_nz = 1'b1;
    case (ctrl.mode_d)
      3'd1: begin
        if (ovf_q)                         seg_n = 8'hBF;
        else if (lead_nz || idx_q == '0)   seg_n = digit_code(nib);
      end
      3'd2: begin
        case (idx_q)
          IDX_W'(3): seg_n = 8'hA1;
          IDX_W'(2): seg_n = 8'hAF;
          IDX_W'(1): seg_n = 8'h88;
          IDX_W'(0): seg_n = 8'hC1;
          default:   seg_n = 8'hFF;
        endcase
      end
      3'd3: begin
        case (idx_q)
          IDX_W'(3): seg_n = 8'h8C;
          IDX_W'(2): seg_n = 8'hF9;
          default:   seg_n = 8'hFF;
        endcase
      end
      3'd4: begin
        case (idx_q)
          IDX_W'(3): seg_n = 8'h8C;
          IDX_W'(2): seg_n = 8'hA4;
          default:   seg_n = 8'hFF;
        endcase
      end
      default: seg_n = 8'hFF;
    endcase
    if (ctrl.blink_en_d && blink_q[BLINK_LOG2]) seg_n = 8'hFF;
  end

  // Registered anode and segment pins.
  always_ff @(posedge clk_d) begin
    if (!rst_n_d) begin
      an_q  <= '1;
      seg_q <= 8'hFF;
    end else begin
      an_q  <= an_n;
      seg_q <= seg_n;
    end
  end

  assign an_d  = an_q;
  assign seg_d = seg_q;

endmodule
